// File: rtl/adma_desc_submitter_if.sv
// Bundle of the descriptor request port and the AXI4 write-only master channels.
// No logic; all timing lives in the submitter that uses the master modport.
// Backpressure is plain valid/ready on every channel carried here.
interface adma_desc_submitter_if #(
    parameter int DMA_WR_CHN_NUM = 4,
    parameter int DMA_LENGTH_W   = 16,
    parameter int SRC_ADDR_W     = 32,
    parameter int DST_ADDR_W     = 32,
    parameter int M_DATA_W       = 32,
    parameter int M_ADDR_W       = 32,
    parameter int MST_ID_W       = 5
);
    localparam int CHN_W = (DMA_WR_CHN_NUM > 1) ? $clog2(DMA_WR_CHN_NUM) : 1;

    // descriptor request
    logic                    desc_vld_i;
    logic                    desc_rdy_o;
    logic [CHN_W-1:0]        desc_chn_i;
    logic [SRC_ADDR_W-1:0]   desc_src_addr_i;
    logic [DST_ADDR_W-1:0]   desc_dst_addr_i;
    logic [DMA_LENGTH_W-1:0] desc_xlen_i;
    logic [DMA_LENGTH_W-1:0] desc_ylen_i;
    logic [DMA_LENGTH_W-1:0] desc_src_strd_i;
    logic [DMA_LENGTH_W-1:0] desc_dst_strd_i;

    // AXI4 write address
    logic [MST_ID_W-1:0]     m_awid_o;
    logic [M_ADDR_W-1:0]     m_awaddr_o;
    logic [7:0]              m_awlen_o;
    logic [1:0]              m_awburst_o;
    logic                    m_awvalid_o;
    logic                    m_awready_i;

    // AXI4 write data
    logic [M_DATA_W-1:0]     m_wdata_o;
    logic                    m_wlast_o;
    logic                    m_wvalid_o;
    logic                    m_wready_i;

    // AXI4 write response
    logic [MST_ID_W-1:0]     m_bid_i;
    logic [1:0]              m_bresp_i;
    logic                    m_bvalid_i;
    logic                    m_bready_o;

    // submitter side
    modport master (
        input  desc_vld_i, desc_chn_i, desc_src_addr_i, desc_dst_addr_i,
               desc_xlen_i, desc_ylen_i, desc_src_strd_i, desc_dst_strd_i,
        output desc_rdy_o,
        output m_awid_o, m_awaddr_o, m_awlen_o, m_awburst_o, m_awvalid_o,
        input  m_awready_i,
        output m_wdata_o, m_wlast_o, m_wvalid_o,
        input  m_wready_i,
        input  m_bid_i, m_bresp_i, m_bvalid_i,
        output m_bready_o
    );

    // requester / CSR slave side
    modport slave (
        output desc_vld_i, desc_chn_i, desc_src_addr_i, desc_dst_addr_i,
               desc_xlen_i, desc_ylen_i, desc_src_strd_i, desc_dst_strd_i,
        input  desc_rdy_o,
        input  m_awid_o, m_awaddr_o, m_awlen_o, m_awburst_o, m_awvalid_o,
        output m_awready_i,
        input  m_wdata_o, m_wlast_o, m_wvalid_o,
        output m_wready_i,
        output m_bid_i, m_bresp_i, m_bvalid_i,
        input  m_bready_o
    );
endinterface

// File: rtl/adma_desc_submitter.sv
// Programs one DMA descriptor (INCR burst to regs 9..14) then rings the channel doorbell.
// Latency: AW, W beats and B each take >=1 cycle; FIN pulses sub_done_o one cycle.
// Backpressure: desc_rdy_o only in IDLE; AXI valids and payload held until ready.
// Option ADMA_DESC_SUB_1D_ONLY_EN: burst writes only regs 9..11 (src, dst, xlen).
module adma_desc_submitter #(
    parameter logic [31:0] DMA_BASE_ADDR   = 32'h8000_0000,
    parameter int          DMA_WR_CHN_NUM  = 4,
    parameter int          DMA_LENGTH_W    = 16,
    parameter int          SRC_ADDR_W      = 32,
    parameter int          DST_ADDR_W      = 32,
    parameter int          M_DATA_W        = 32,
    parameter int          M_ADDR_W        = 32,
    parameter int          MST_ID_W        = 5,
    parameter int          MST_ID          = 0,
    parameter int          REG_ADDR_STRIDE = 1
) (
    input  logic aclk,
    input  logic aresetn,
    adma_desc_submitter_if.master bus,
    output logic sub_busy_o,
    output logic sub_done_o,
    output logic sub_err_o
);
    localparam int CHN_W    = (DMA_WR_CHN_NUM > 1) ? $clog2(DMA_WR_CHN_NUM) : 1;
    localparam int CHN_SPAN = 1 << CHN_W;

`ifdef ADMA_DESC_SUB_1D_ONLY_EN
    localparam logic [2:0] LAST_BEAT = 3'd2;
`else
    localparam logic [2:0] LAST_BEAT = 3'd5;
`endif

    localparam logic [M_ADDR_W-1:0] BASE_A     = M_ADDR_W'(DMA_BASE_ADDR);
    localparam logic [M_ADDR_W-1:0] STRIDE_A   = M_ADDR_W'(REG_ADDR_STRIDE);
    localparam logic [M_ADDR_W-1:0] BELL_OFS_A = M_ADDR_W'(32'h1000);

    // One bit per encodable channel number: set when that channel exists.
    // Avoids a range compare that is constant when the channel count is a power of two.
    function automatic logic [CHN_SPAN-1:0] chn_ok_mask_f();
        logic [CHN_SPAN-1:0] m;
        m = '0;
        for (int i = 0; i < CHN_SPAN; i++) begin
            m[i] = (i < DMA_WR_CHN_NUM);
        end
        return m;
    endfunction

    localparam logic [CHN_SPAN-1:0] CHN_OK = chn_ok_mask_f();

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D_AW = 3'd1,
        D_W  = 3'd2,
        D_B  = 3'd3,
        K_AW = 3'd4,
        K_W  = 3'd5,
        K_B  = 3'd6,
        FIN  = 3'd7
    } state_e;

    state_e state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic       err_q, err_d;

    logic [CHN_W-1:0]        chn_q;
    logic [SRC_ADDR_W-1:0]   src_q;
    logic [DST_ADDR_W-1:0]   dst_q;
    logic [DMA_LENGTH_W-1:0] xlen_q;
`ifndef ADMA_DESC_SUB_1D_ONLY_EN
    logic [DMA_LENGTH_W-1:0] ylen_q;
    logic [DMA_LENGTH_W-1:0] sstr_q;
    logic [DMA_LENGTH_W-1:0] dstr_q;
`endif

    logic                accept;
    logic                bresp_bad;
    logic [M_ADDR_W-1:0] chn_ext;
    logic [M_ADDR_W-1:0] desc_addr;
    logic [M_ADDR_W-1:0] bell_addr;
    logic [M_DATA_W-1:0] field_dat;
    logic                unused_bits;

    assign accept    = bus.desc_vld_i && (state_q == IDLE);
    assign bresp_bad = (bus.m_bresp_i != 2'b00);

    // B id carries nothing this single-ID master needs.
`ifdef ADMA_DESC_SUB_1D_ONLY_EN
    assign unused_bits = ^{bus.m_bid_i, bus.desc_ylen_i, bus.desc_src_strd_i, bus.desc_dst_strd_i};
`else
    assign unused_bits = ^bus.m_bid_i;
`endif

    // Descriptor capture on accept; fields stay frozen for the whole submission.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            chn_q  <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            xlen_q <= '0;
`ifndef ADMA_DESC_SUB_1D_ONLY_EN
            ylen_q <= '0;
            sstr_q <= '0;
            dstr_q <= '0;
`endif
        end else if (accept) begin
            chn_q  <= bus.desc_chn_i;
            src_q  <= bus.desc_src_addr_i;
            dst_q  <= bus.desc_dst_addr_i;
            xlen_q <= bus.desc_xlen_i;
`ifndef ADMA_DESC_SUB_1D_ONLY_EN
            ylen_q <= bus.desc_ylen_i;
            sstr_q <= bus.desc_src_strd_i;
            dstr_q <= bus.desc_dst_strd_i;
`endif
        end
    end

    // FSM state, beat counter and sticky error flag.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: descriptor burst, its response, doorbell write, its response, report.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                beat_d = 3'd0;
                if (accept) begin
                    // Nonexistent channel: report an error without touching the bus.
                    err_d   = !CHN_OK[bus.desc_chn_i];
                    state_d = CHN_OK[bus.desc_chn_i] ? D_AW : FIN;
                end
            end
            D_AW: begin
                if (bus.m_awready_i) begin
                    state_d = D_W;
                end
            end
            D_W: begin
                if (bus.m_wready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 3'd0;
                        state_d = D_B;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            D_B: begin
                if (bus.m_bvalid_i) begin
                    // A rejected descriptor must not be kicked off.
                    if (bresp_bad) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = K_AW;
                    end
                end
            end
            K_AW: begin
                if (bus.m_awready_i) begin
                    state_d = K_W;
                end
            end
            K_W: begin
                if (bus.m_wready_i) begin
                    state_d = K_B;
                end
            end
            K_B: begin
                if (bus.m_bvalid_i) begin
                    err_d   = err_q | bresp_bad;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register addresses for the captured channel.
    always_comb begin
        chn_ext   = M_ADDR_W'(chn_q);
        desc_addr = BASE_A + (chn_ext * M_ADDR_W'(16) + M_ADDR_W'(9)) * STRIDE_A;
        bell_addr = BASE_A + BELL_OFS_A + chn_ext * M_ADDR_W'(16) * STRIDE_A;
    end

    // Beat-to-register mapping: 9 src, 10 dst, 11 xlen, 12 ylen, 13 src stride, 14 dst stride.
    always_comb begin
        field_dat = '0;
        case (beat_q)
            3'd0:    field_dat = M_DATA_W'(src_q);
            3'd1:    field_dat = M_DATA_W'(dst_q);
            3'd2:    field_dat = M_DATA_W'(xlen_q);
`ifndef ADMA_DESC_SUB_1D_ONLY_EN
            3'd3:    field_dat = M_DATA_W'(ylen_q);
            3'd4:    field_dat = M_DATA_W'(sstr_q);
            3'd5:    field_dat = M_DATA_W'(dstr_q);
`endif
            default: field_dat = '0;
        endcase
    end

    // Bus outputs are pure functions of registered state, so they cannot move during a stall.
    always_comb begin
        bus.desc_rdy_o  = (state_q == IDLE);
        bus.m_awid_o    = MST_ID_W'(MST_ID);
        bus.m_awburst_o = 2'b01;
        bus.m_awvalid_o = (state_q == D_AW) || (state_q == K_AW);
        bus.m_awaddr_o  = '0;
        bus.m_awlen_o   = 8'd0;
        bus.m_wvalid_o  = (state_q == D_W) || (state_q == K_W);
        bus.m_wdata_o   = '0;
        bus.m_wlast_o   = 1'b0;
        bus.m_bready_o  = (state_q == D_B) || (state_q == K_B);
        sub_busy_o      = (state_q != IDLE);
        sub_done_o      = (state_q == FIN);
        sub_err_o       = (state_q == FIN) && err_q;
        case (state_q)
            D_AW: begin
                bus.m_awaddr_o = desc_addr;
                bus.m_awlen_o  = 8'(LAST_BEAT);
            end
            D_W: begin
                bus.m_wdata_o = field_dat;
                bus.m_wlast_o = (beat_q == LAST_BEAT);
            end
            K_AW: begin
                bus.m_awaddr_o = bell_addr;
            end
            K_W: begin
                bus.m_wdata_o = M_DATA_W'(1);
                bus.m_wlast_o = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_adma_desc_submitter.sv
// Bench for adma_desc_submitter with a scoreboard of expected AW, W and done events.
// Three channels are configured so that channel 3 is encodable but nonexistent.
// AXI readies and B valid are randomly throttled in the stall phases.
module tb_adma_desc_submitter;
    localparam int          N_CHN = 3;
    localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef ADMA_DESC_SUB_1D_ONLY_EN
    localparam int NB = 3;
`else
    localparam int NB = 6;
`endif
    localparam int RST_BEAT = (NB > 3) ? 3 : NB - 1;

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic last; } w_t;

    logic aclk;
    logic aresetn;
    logic sub_busy_o, sub_done_o, sub_err_o;

    adma_desc_submitter_if #(.DMA_WR_CHN_NUM(N_CHN)) bus ();

    adma_desc_submitter #(.DMA_WR_CHN_NUM(N_CHN)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .bus        (bus.master),
        .sub_busy_o (sub_busy_o),
        .sub_done_o (sub_done_o),
        .sub_err_o  (sub_err_o)
    );

    aw_t exp_aw[$];
    w_t  exp_w[$];
    bit  exp_done[$];

    int n_chk = 0;
    int n_err = 0;
    int w_seen = 0;
    int done_seen = 0;
    int b_cnt = 0;
    bit b_hs = 0;
    bit rnd_mode = 0;
    logic b_en = 1'b1;
    logic [1:0] resp0 = 2'b00;
    logic [1:0] resp1 = 2'b00;

    bit          aw_stall = 0;
    logic [31:0] aw_prev_addr = '0;
    bit          w_stall = 0;
    logic [31:0] w_prev_data = '0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    assign bus.m_bvalid_i = bus.m_bready_o & b_en;
    assign bus.m_bresp_i  = (b_cnt == 0) ? resp0 : resp1;
    assign bus.m_bid_i    = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave-side readiness, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (b_hs) begin
                b_cnt++;
                b_hs = 0;
            end
            bus.m_awready_i = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.m_wready_i  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            b_en            = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshakes are judged mid-cycle, before the edge that completes them.
    always @(negedge aclk) begin
        if (!aresetn) begin
            aw_stall = 0;
            w_stall  = 0;
        end else begin
            if (aw_stall) begin
                check("aw_hold_vld", 64'(bus.m_awvalid_o), 64'(1));
                check("aw_hold_addr", 64'(bus.m_awaddr_o), 64'(aw_prev_addr));
            end
            if (w_stall) begin
                check("w_hold_vld", 64'(bus.m_wvalid_o), 64'(1));
                check("w_hold_data", 64'(bus.m_wdata_o), 64'(w_prev_data));
            end
            if (bus.m_awvalid_o) begin
                check("aw_w_overlap", 64'(bus.m_wvalid_o), 64'(0));
                if (exp_aw.size() == 0) begin
                    check("aw_unexpected_vld", 64'(bus.m_awvalid_o), 64'(0));
                end else if (bus.m_awready_i) begin
                    aw_t e;
                    e = exp_aw.pop_front();
                    check("awaddr", 64'(bus.m_awaddr_o), 64'(e.addr));
                    check("awlen", 64'(bus.m_awlen_o), 64'(e.len));
                    check("awburst", 64'(bus.m_awburst_o), 64'(2'b01));
                    check("awid", 64'(bus.m_awid_o), 64'(0));
                end
            end
            if (bus.m_wvalid_o) begin
                if (exp_w.size() == 0 || exp_w.size() > exp_aw.size() * NB + NB + 1 && exp_aw.size() > 0) begin
                    check("w_unexpected_vld", 64'(bus.m_wvalid_o), 64'(0));
                end else if (bus.m_wready_i) begin
                    w_t e;
                    e = exp_w.pop_front();
                    check("wdata", 64'(bus.m_wdata_o), 64'(e.data));
                    check("wlast", 64'(bus.m_wlast_o), 64'(e.last));
                    w_seen++;
                end
            end
            if (bus.m_bvalid_i && bus.m_bready_o) b_hs = 1;
            if (sub_done_o) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 64'(sub_done_o), 64'(0));
                end else begin
                    check("sub_err", 64'(sub_err_o), 64'(exp_done.pop_front()));
                end
                done_seen++;
            end else begin
                check("err_without_done", 64'(sub_err_o), 64'(0));
            end
            aw_stall     = bus.m_awvalid_o && !bus.m_awready_i;
            aw_prev_addr = bus.m_awaddr_o;
            w_stall      = bus.m_wvalid_o && !bus.m_wready_i;
            w_prev_data  = bus.m_wdata_o;
        end
    end

    // Push the expected bus traffic for one descriptor, then present it until accepted.
    task automatic send_desc(input logic [1:0] chn, input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] xl, input logic [15:0] yl, input logic [15:0] ss,
                             input logic [15:0] ds, input logic [1:0] r0, input logic [1:0] r1);
        logic [31:0] f [6];
        aw_t a;
        w_t  w;
        logic acc;
        f[0] = src; f[1] = dst; f[2] = 32'(xl); f[3] = 32'(yl); f[4] = 32'(ss); f[5] = 32'(ds);
        resp0 = r0;
        resp1 = r1;
        b_cnt = 0;
        if (int'(chn) < N_CHN) begin
            a.addr = BASE + 32'(chn) * 32'd16 + 32'd9;
            a.len  = 8'(NB - 1);
            exp_aw.push_back(a);
            for (int i = 0; i < NB; i++) begin
                w.data = f[i];
                w.last = (i == NB - 1);
                exp_w.push_back(w);
            end
            if (r0 == 2'b00) begin
                a.addr = BASE + 32'h1000 + 32'(chn) * 32'd16;
                a.len  = 8'd0;
                exp_aw.push_back(a);
                w.data = 32'd1;
                w.last = 1'b1;
                exp_w.push_back(w);
                exp_done.push_back(r1 != 2'b00);
            end else begin
                exp_done.push_back(1'b1);
            end
        end else begin
            exp_done.push_back(1'b1);
        end
        bus.desc_vld_i      = 1'b1;
        bus.desc_chn_i      = chn;
        bus.desc_src_addr_i = src;
        bus.desc_dst_addr_i = dst;
        bus.desc_xlen_i     = xl;
        bus.desc_ylen_i     = yl;
        bus.desc_src_strd_i = ss;
        bus.desc_dst_strd_i = ds;
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            acc = bus.desc_rdy_o;
            @(posedge aclk);
            #1;
        end
        bus.desc_vld_i = 1'b0;
        check("desc_accept", 64'(acc), 64'(1));
        check("rdy_drop", 64'(bus.desc_rdy_o), 64'(0));
        check("busy_set", 64'(sub_busy_o), 64'(1));
    endtask

    task automatic wait_done();
        int start;
        start = done_seen;
        for (int k = 0; k < 2000 && done_seen == start; k++) begin
            @(posedge aclk);
            #1;
        end
        check("done_seen", 64'(done_seen - start), 64'(1));
        check("rdy_after_done", 64'(bus.desc_rdy_o), 64'(1));
        check("busy_after_done", 64'(sub_busy_o), 64'(0));
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_rdy"}, 64'(bus.desc_rdy_o), 64'(1));
        check({pfx, "_awvalid"}, 64'(bus.m_awvalid_o), 64'(0));
        check({pfx, "_wvalid"}, 64'(bus.m_wvalid_o), 64'(0));
        check({pfx, "_bready"}, 64'(bus.m_bready_o), 64'(0));
        check({pfx, "_awaddr"}, 64'(bus.m_awaddr_o), 64'(0));
        check({pfx, "_awlen"}, 64'(bus.m_awlen_o), 64'(0));
        check({pfx, "_wdata"}, 64'(bus.m_wdata_o), 64'(0));
        check({pfx, "_wlast"}, 64'(bus.m_wlast_o), 64'(0));
        check({pfx, "_busy"}, 64'(sub_busy_o), 64'(0));
        check({pfx, "_done"}, 64'(sub_done_o), 64'(0));
        check({pfx, "_err"}, 64'(sub_err_o), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn             = 1'b0;
        bus.desc_vld_i      = 1'b0;
        bus.desc_chn_i      = '0;
        bus.desc_src_addr_i = '0;
        bus.desc_dst_addr_i = '0;
        bus.desc_xlen_i     = '0;
        bus.desc_ylen_i     = '0;
        bus.desc_src_strd_i = '0;
        bus.desc_dst_strd_i = '0;
        bus.m_awready_i     = 1'b0;
        bus.m_wready_i      = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_idle_outputs("reset");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Nominal descriptor, always-ready slave.
        rnd_mode = 0;
        send_desc(2'd2, 32'h1000_0000, 32'h2000_0000, 16'h0040, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00);
        wait_done();

        // Same descriptor and a few random ones under random stalls, sent back to back.
        rnd_mode = 1;
        send_desc(2'd2, 32'h1000_0000, 32'h2000_0000, 16'h0040, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00);
        wait_done();
        for (int t = 0; t < 5; t++) begin
            send_desc(2'($urandom_range(0, N_CHN - 1)), $urandom, $urandom,
                      16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      2'b00, ($urandom_range(0, 2) == 0) ? 2'b11 : 2'b00);
            wait_done();
        end

        // Descriptor write rejected: no doorbell, done and err together.
        rnd_mode = 0;
        send_desc(2'd1, 32'hAAAA_0000, 32'hBBBB_0000, 16'h0100, 16'h0002, 16'h0010, 16'h0020,
                  2'b10, 2'b00);
        wait_done();

        // Doorbell write rejected.
        rnd_mode = 1;
        send_desc(2'd0, 32'h0000_1234, 32'h0000_5678, 16'h0008, 16'h0001, 16'h0004, 16'h0004,
                  2'b00, 2'b10);
        wait_done();

        // Channel that does not exist: accepted, dropped, error reported, no AXI traffic.
        rnd_mode = 0;
        send_desc(2'd3, 32'hDEAD_0000, 32'hBEEF_0000, 16'h0010, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00);
        wait_done();

        // Reset in the middle of the descriptor burst, then a clean submission.
        begin
            int ws;
            ws = w_seen;
            send_desc(2'd1, 32'h3000_0000, 32'h4000_0000, 16'h0080, 16'h0003, 16'h0100, 16'h0200,
                      2'b00, 2'b00);
            for (int k = 0; k < 200 && w_seen < ws + RST_BEAT; k++) begin
                @(posedge aclk);
                #1;
            end
            check("mid_burst_wvalid", 64'(bus.m_wvalid_o), 64'(1));
            aresetn = 1'b0;
            @(posedge aclk);
            #1;
            check_idle_outputs("midrst");
            aresetn = 1'b1;
            exp_aw.delete();
            exp_w.delete();
            exp_done.delete();
        end
        send_desc(2'd0, 32'h0000_0100, 32'h0000_0200, 16'h0030, 16'h0004, 16'h0008, 16'h000C,
                  2'b00, 2'b00);
        wait_done();

        repeat (3) @(posedge aclk);
        #1;
        check("exp_aw_left", 64'(exp_aw.size()), 64'(0));
        check("exp_w_left", 64'(exp_w.size()), 64'(0));
        check("exp_done_left", 64'(exp_done.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
